// File: rtl/pw_channel_accumulator.sv
// Pointwise-conv channel accumulator: sums IN_CHANNELS products per output channel,
// saturates to N bits and drains them from a double buffer. Optional per-channel bias: PW_ACC_BIAS_EN.
module pw_channel_accumulator #(
    parameter int N            = 16,
    parameter int Q            = 8,
    parameter int IN_CHANNELS  = 24,
    parameter int OUT_CHANNELS = 24,
    parameter int FEATURE_SIZE = 28,
    localparam int CH_W  = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1,
    localparam int PIX_W = $clog2(FEATURE_SIZE * FEATURE_SIZE) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N-1:0]              data_in,
    input  logic [CH_W-1:0]           channel_in,
    input  logic                      valid_in,
    input  logic [OUT_CHANNELS*N-1:0] bias,
    output logic [N-1:0]              data_out,
    output logic [CH_W-1:0]           channel_out,
    output logic                      valid_out,
    input  logic                      out_ready,
    output logic [PIX_W-1:0]          pixel_cnt,
    output logic                      done,
    output logic                      overrun,
    output logic                      seq_err
);

    localparam int IN_W    = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int ACC_W   = N + $clog2(IN_CHANNELS) + 1;
    localparam int SUM_W   = ACC_W + 1;
    localparam int NUM_PIX = FEATURE_SIZE * FEATURE_SIZE;

    localparam logic [CH_W:0]            OUT_LIM = (CH_W + 1)'(OUT_CHANNELS);
    localparam logic signed [SUM_W-1:0]  SAT_HI  = SUM_W'((64'sd1 <<< (N - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0]  SAT_LO  = ~SAT_HI;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_r, state_s;

    logic signed [ACC_W-1:0] acc_r      [OUT_CHANNELS];
    logic signed [ACC_W-1:0] acc_fin_s  [OUT_CHANNELS];
    logic signed [SUM_W-1:0] sum_s      [OUT_CHANNELS];
    logic [N-1:0]            snap_val_s [OUT_CHANNELS];
    logic [N-1:0]            bank_r     [OUT_CHANNELS];

    logic [CH_W-1:0]  exp_ch_r;
    logic [IN_W-1:0]  in_cnt_r;
    logic [N-1:0]     data_out_r;
    logic [CH_W-1:0]  channel_out_r;
    logic             valid_out_r;
    logic [PIX_W-1:0] pixel_cnt_r;
    logic             done_r;
    logic             overrun_r;
    logic             seq_err_r;

    logic signed [ACC_W-1:0] din_ext_s;
    logic [CH_W-1:0]         nxt_ch_s;
    logic accept_s, clear_s, ch_ok_s, pix_done_s;
    logic hs_s, last_hs_s, snap_s, drop_s, final_pix_s;

    // Keeps configuration-only inputs visibly consumed when the bias adder is absent.
    logic unused_cfg_s;
    assign unused_cfg_s = ^{bias, 32'(Q)};

    function automatic logic [N-1:0] sat_n(input logic signed [SUM_W-1:0] v);
        logic [N-1:0] r;
        if (v > SAT_HI) begin
            r = {1'b0, {(N-1){1'b1}}};
        end else if (v < SAT_LO) begin
            r = {1'b1, {(N-1){1'b0}}};
        end else begin
            r = v[N-1:0];
        end
        return r;
    endfunction

    // Handshake and pixel-boundary decode.
    always_comb begin
        accept_s    = (state_r == ST_ACCUM) && en && valid_in;
        clear_s     = (state_r != ST_IDLE) && !en;
        ch_ok_s     = ({1'b0, channel_in} < OUT_LIM);
        din_ext_s   = {{(ACC_W-N){data_in[N-1]}}, data_in};
        pix_done_s  = accept_s && (exp_ch_r == CH_W'(OUT_CHANNELS - 1))
                               && (in_cnt_r == IN_W'(IN_CHANNELS - 1));
        hs_s        = valid_out_r && out_ready;
        last_hs_s   = hs_s && (channel_out_r == CH_W'(OUT_CHANNELS - 1));
        // A bank that empties on this very edge can take the new snapshot.
        snap_s      = pix_done_s && (!valid_out_r || last_hs_s);
        drop_s      = pix_done_s && valid_out_r && !last_hs_s;
        final_pix_s = last_hs_s && (state_r == ST_ACCUM)
                                && (pixel_cnt_r == PIX_W'(NUM_PIX - 1));
        nxt_ch_s    = channel_out_r + CH_W'(1);
    end

    // Per-channel sums including the product accepted this cycle, then saturated.
    always_comb begin
        for (int c = 0; c < OUT_CHANNELS; c++) begin
            if (accept_s && ch_ok_s && (channel_in == CH_W'(c))) begin
                acc_fin_s[c] = acc_r[c] + din_ext_s;
            end else begin
                acc_fin_s[c] = acc_r[c];
            end
`ifdef PW_ACC_BIAS_EN
            sum_s[c] = {acc_fin_s[c][ACC_W-1], acc_fin_s[c]}
                     + {{(SUM_W-N){bias[c*N+N-1]}}, bias[c*N +: N]};
`else
            sum_s[c] = {acc_fin_s[c][ACC_W-1], acc_fin_s[c]};
`endif
            snap_val_s[c] = sat_n(sum_s[c]);
        end
    end

    // Frame FSM next state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) state_s = ST_ACCUM;
                else    state_s = ST_IDLE;
            end
            ST_ACCUM: begin
                if (!en)              state_s = ST_IDLE;
                else if (final_pix_s) state_s = ST_DONE;
                else                  state_s = ST_ACCUM;
            end
            ST_DONE: begin
                if (!en) state_s = ST_IDLE;
                else     state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state, status flags and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pixel_cnt_r <= '0;
            done_r      <= 1'b0;
            overrun_r   <= 1'b0;
            seq_err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_s == ST_DONE);
            if (clear_s) begin
                pixel_cnt_r <= '0;
            end else if (last_hs_s && (state_r == ST_ACCUM)) begin
                pixel_cnt_r <= pixel_cnt_r + PIX_W'(1);
            end else begin
                pixel_cnt_r <= pixel_cnt_r;
            end
            if (drop_s) overrun_r <= 1'b1;
            else        overrun_r <= overrun_r;
            if (accept_s && (channel_in != exp_ch_r)) seq_err_r <= 1'b1;
            else                                      seq_err_r <= seq_err_r;
        end
    end

    // Accumulators and the expected-channel / product counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < OUT_CHANNELS; c++) acc_r[c] <= '0;
            exp_ch_r <= '0;
            in_cnt_r <= '0;
        end else if (clear_s || pix_done_s) begin
            for (int c = 0; c < OUT_CHANNELS; c++) acc_r[c] <= '0;
            exp_ch_r <= '0;
            in_cnt_r <= '0;
        end else begin
            for (int c = 0; c < OUT_CHANNELS; c++) acc_r[c] <= acc_fin_s[c];
            if (accept_s) begin
                if (exp_ch_r == CH_W'(OUT_CHANNELS - 1)) begin
                    exp_ch_r <= '0;
                    in_cnt_r <= in_cnt_r + IN_W'(1);
                end else begin
                    exp_ch_r <= exp_ch_r + CH_W'(1);
                    in_cnt_r <= in_cnt_r;
                end
            end else begin
                exp_ch_r <= exp_ch_r;
                in_cnt_r <= in_cnt_r;
            end
        end
    end

    // Output bank: snapshot on pixel completion, one channel per handshake; valid_out marks it full.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < OUT_CHANNELS; c++) bank_r[c] <= '0;
            data_out_r    <= '0;
            channel_out_r <= '0;
            valid_out_r   <= 1'b0;
        end else if (snap_s) begin
            for (int c = 0; c < OUT_CHANNELS; c++) bank_r[c] <= snap_val_s[c];
            data_out_r    <= snap_val_s[0];
            channel_out_r <= '0;
            valid_out_r   <= 1'b1;
        end else if (last_hs_s) begin
            data_out_r    <= '0;
            channel_out_r <= '0;
            valid_out_r   <= 1'b0;
        end else if (hs_s) begin
            data_out_r    <= bank_r[nxt_ch_s];
            channel_out_r <= nxt_ch_s;
            valid_out_r   <= 1'b1;
        end else begin
            data_out_r    <= data_out_r;
            channel_out_r <= channel_out_r;
            valid_out_r   <= valid_out_r;
        end
    end

    assign data_out    = data_out_r;
    assign channel_out = channel_out_r;
    assign valid_out   = valid_out_r;
    assign pixel_cnt   = pixel_cnt_r;
    assign done        = done_r;
    assign overrun     = overrun_r;
    assign seq_err     = seq_err_r;

endmodule

// File: tb/tb_pw_channel_accumulator.sv
// Bench for pw_channel_accumulator: a 2x2-channel 28x28 instance (directed + random frame)
// and a 24-input instance driven from a saturation vector table.
module tb_pw_channel_accumulator;

    logic        clk = 1'b0;
    logic        rst, en_a, en_b, valid_a, valid_b;
    logic [15:0] din;
    logic        ch_in;
    logic [31:0] bias_a, bias_b;
    logic        ready_man, ready_rnd, rand_ready;
    logic        ready;

    logic [15:0] dout_a, dout_b;
    logic        chout_a, chout_b, vout_a, vout_b;
    logic [10:0] pcnt_a;
    logic [4:0]  pcnt_b;
    logic        done_a, done_b, ovr_a, ovr_b, serr_a, serr_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [16:0] exp_a[$];
    logic [16:0] exp_b[$];
    logic [16:0] e_a, e_b, captured;

    assign ready = rand_ready ? ready_rnd : ready_man;

    pw_channel_accumulator #(.N(16), .Q(8), .IN_CHANNELS(2), .OUT_CHANNELS(2), .FEATURE_SIZE(28)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .data_in(din), .channel_in(ch_in), .valid_in(valid_a),
        .bias(bias_a), .data_out(dout_a), .channel_out(chout_a), .valid_out(vout_a),
        .out_ready(ready), .pixel_cnt(pcnt_a), .done(done_a), .overrun(ovr_a), .seq_err(serr_a));

    pw_channel_accumulator #(.N(16), .Q(8), .IN_CHANNELS(24), .OUT_CHANNELS(2), .FEATURE_SIZE(3)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .data_in(din), .channel_in(ch_in), .valid_in(valid_b),
        .bias(bias_b), .data_out(dout_b), .channel_out(chout_b), .valid_out(vout_b),
        .out_ready(ready), .pixel_cnt(pcnt_b), .done(done_b), .overrun(ovr_b), .seq_err(serr_b));

    initial forever #5 clk = ~clk;

`ifdef PW_ACC_BIAS_EN
    localparam longint BIAS_ON = 64'sd1;
`else
    localparam longint BIAS_ON = 64'sd0;
`endif

    function automatic logic [15:0] sat16(input longint s);
        if (s > 64'sd32767)       return 16'h7FFF;
        else if (s < -64'sd32768) return 16'h8000;
        else                      return s[15:0];
    endfunction

    function automatic longint bias_a_of(input int c);
        logic [15:0] b;
        b = bias_a[c*16 +: 16];
        return BIAS_ON * longint'($signed(b));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic send(input bit which, input logic c, input logic [15:0] d);
        din   = d;
        ch_in = c;
        if (which) valid_b = 1'b1;
        else       valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic wait_drain(input bit which, input int bound, input string name);
        int k;
        k = 0;
        while (k < bound && ((which ? exp_b.size() : exp_a.size()) != 0 || (which ? vout_b : vout_a))) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= bound)
            $display("FAIL %s: drain unfinished after %0d cycles, %0d outputs outstanding", name, bound,
                     which ? exp_b.size() : exp_a.size());
        else
            n_pass++;
    endtask

    // Scoreboards: every accepted output must match the next expected {channel, data}.
    always @(negedge clk) begin
        if (!rst && vout_a && ready) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                $display("FAIL drain_a: got ch=%0d data=%h expected no output", chout_a, dout_a);
            end else begin
                e_a = exp_a.pop_front();
                check("drain_a", {15'd0, chout_a, dout_a}, {15'd0, e_a});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && vout_b && ready) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                $display("FAIL drain_b: got ch=%0d data=%h expected no output", chout_b, dout_b);
            end else begin
                e_b = exp_b.pop_front();
                check("drain_b", {15'd0, chout_b, dout_b}, {15'd0, e_b});
            end
        end
    end

    initial begin
        ready_rnd = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_rnd = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] a0, a1, ar;   // ch0 products: first, second, remaining 22
        logic [15:0] b0, b1, br;   // ch1 products
        logic [15:0] e0, e1;       // expected saturated sums
    } vec_t;

    vec_t        tbl [6];
    logic [15:0] v [2][2];
    longint      s;

    initial begin
        tbl[0] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h8000};
        tbl[1] = '{16'h7FFF, 16'h8001, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0018};
        tbl[2] = '{16'h0100, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0100, 16'hFFE8};
        tbl[3] = '{16'h0800, 16'h0800, 16'h0800, 16'hF800, 16'hF800, 16'hF800, 16'h7FFF, 16'h8000};
        tbl[4] = '{16'h0555, 16'h0555, 16'h0555, 16'h8000, 16'h7FFF, 16'h0000, 16'h7FF8, 16'hFFFF};
        tbl[5] = '{16'h4000, 16'h3FFF, 16'h0000, 16'hC000, 16'hC000, 16'h0000, 16'h7FFF, 16'h8000};

        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        din = 16'h0000; ch_in = 1'b0; ready_man = 1'b0; rand_ready = 1'b0;
        bias_a = 32'h0000_0100;
        bias_b = 32'h0000_0000;
        repeat (3) tick();
        check("reset_a", {vout_a, dout_a, chout_a, pcnt_a, done_a, ovr_a, serr_a}, 32'd0);
        check("reset_b", {vout_b, dout_b, chout_b, pcnt_b, done_b, ovr_b, serr_b}, 32'd0);
        rst = 1'b0;
        tick();

        // T1: two products per channel, one-cycle latency to first output
        en_a = 1'b1; ready_man = 1'b1;
        tick();
        exp_a.push_back({1'b0, sat16(64'sd384 + bias_a_of(0))});
        exp_a.push_back({1'b1, sat16(64'sd256 + bias_a_of(1))});
        send(1'b0, 1'b0, 16'h0100);
        send(1'b0, 1'b1, 16'h0200);
        send(1'b0, 1'b0, 16'h0080);
        check("t1_no_early_valid", {31'd0, vout_a}, 32'd0);
        send(1'b0, 1'b1, 16'hFF00);
        check("t1_latency", {30'd0, vout_a, chout_a}, {30'd0, 1'b1, 1'b0});
        tick();
        tick();
        check("t1_pixel_cnt", {20'd0, vout_a, pcnt_a}, {20'd0, 1'b0, 11'd1});

        // T3: stall five cycles between ch0 and ch1
        ready_man = 1'b0;
        exp_a.push_back({1'b0, sat16(64'sd40 + bias_a_of(0))});
        exp_a.push_back({1'b1, sat16(64'sd60 + bias_a_of(1))});
        send(1'b0, 1'b0, 16'd10);
        send(1'b0, 1'b1, 16'd20);
        send(1'b0, 1'b0, 16'd30);
        send(1'b0, 1'b1, 16'd40);
        ready_man = 1'b1;
        tick();
        ready_man = 1'b0;
        captured = {chout_a, dout_a};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold", {14'd0, vout_a, chout_a, dout_a}, {14'd0, 1'b1, captured});
        end
        ready_man = 1'b1;
        tick();
        check("t3_no_loss", {20'd0, vout_a, pcnt_a}, {20'd0, 1'b0, 11'd2});
        check("t3_queue_empty", exp_a.size(), 32'd0);

        // T4: second pixel completes while the first is still held
        ready_man = 1'b0;
        exp_a.push_back({1'b0, sat16(64'sd4352 + bias_a_of(0))});
        exp_a.push_back({1'b1, sat16(-64'sd2 + bias_a_of(1))});
        send(1'b0, 1'b0, 16'h1000);
        send(1'b0, 1'b1, 16'hFFFF);
        send(1'b0, 1'b0, 16'h0100);
        send(1'b0, 1'b1, 16'hFFFF);
        check("t4_no_overrun_yet", {30'd0, vout_a, ovr_a}, {30'd0, 1'b1, 1'b0});
        send(1'b0, 1'b0, 16'h2222);
        send(1'b0, 1'b1, 16'h3333);
        send(1'b0, 1'b0, 16'h0001);
        send(1'b0, 1'b1, 16'h0001);
        check("t4_overrun", {31'd0, ovr_a}, 32'd1);
        ready_man = 1'b1;
        wait_drain(1'b0, 20, "t4_drain");
        check("t4_pixel_cnt", {21'd0, pcnt_a}, 32'd3);

        // T5: channel order 0,0 flags seq_err, which survives leaving the frame
        check("t5_no_seq_err", {31'd0, serr_a}, 32'd0);
        send(1'b0, 1'b0, 16'd5);
        send(1'b0, 1'b0, 16'd6);
        check("t5_seq_err", {31'd0, serr_a}, 32'd1);
        en_a = 1'b0;
        tick();
        tick();
        check("t5_sticky_idle", {19'd0, serr_a, done_a, pcnt_a}, {19'd0, 1'b1, 1'b0, 11'd0});

        // T6: full random 28x28 frame against the reference sums
        en_a = 1'b1;
        rand_ready = 1'b1;
        tick();
        for (int p = 0; p < 784; p++) begin
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < 2; c++)
                    v[k][c] = 16'($urandom);
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < 2; c++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    if (k == 1 && c == 1) begin
                        wait_drain(1'b0, 200, "t6_slot");
                        if (p == 783)
                            check("t6_pre_done", {20'd0, done_a, pcnt_a}, {20'd0, 1'b0, 11'd783});
                        for (int oc = 0; oc < 2; oc++) begin
                            s = longint'($signed(v[0][oc])) + longint'($signed(v[1][oc])) + bias_a_of(oc);
                            exp_a.push_back({oc[0], sat16(s)});
                        end
                    end
                    send(1'b0, c[0], v[k][c]);
                end
        end
        wait_drain(1'b0, 200, "t6_drain");
        check("t6_done", {20'd0, done_a, pcnt_a}, {20'd0, 1'b1, 11'd784});
        send(1'b0, 1'b0, 16'h0001);
        send(1'b0, 1'b1, 16'h0001);
        send(1'b0, 1'b0, 16'h0001);
        send(1'b0, 1'b1, 16'h0001);
        repeat (3) tick();
        check("t6_done_ignores_input", {20'd0, vout_a, pcnt_a}, {20'd0, 1'b0, 11'd784});
        en_a = 1'b0;
        tick();
        check("t6_done_clear", {20'd0, done_a, pcnt_a}, 32'd0);
        rand_ready = 1'b0;

        // T2: saturation vectors on the 24-input instance
        en_b = 1'b1; ready_man = 1'b1;
        tick();
        for (int t = 0; t < 6; t++) begin
            exp_b.push_back({1'b0, tbl[t].e0});
            exp_b.push_back({1'b1, tbl[t].e1});
            for (int k = 0; k < 24; k++) begin
                send(1'b1, 1'b0, (k == 0) ? tbl[t].a0 : (k == 1) ? tbl[t].a1 : tbl[t].ar);
                send(1'b1, 1'b1, (k == 0) ? tbl[t].b0 : (k == 1) ? tbl[t].b1 : tbl[t].br);
            end
            wait_drain(1'b1, 20, "t2_drain");
        end
        check("t2_pixel_cnt", {27'd0, pcnt_b}, 32'd6);

        // rst mid-frame aborts a held output and clears sticky flags
        check("sticky_before_rst", {30'd0, ovr_a, serr_a}, 32'd3);
        en_a = 1'b1; ready_man = 1'b0;
        tick();
        send(1'b0, 1'b0, 16'd1);
        send(1'b0, 1'b1, 16'd2);
        send(1'b0, 1'b0, 16'd3);
        send(1'b0, 1'b1, 16'd4);
        check("rst_pre_valid", {31'd0, vout_a}, 32'd1);
        rst = 1'b1;
        tick();
        check("rst_abort", {vout_a, ovr_a, serr_a, pcnt_a, dout_a, done_a}, 32'd0);
        rst = 1'b0; en_a = 1'b0; en_b = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
